cmlk_frame_ctrl: RTL and testbench

CMLK_FRAME_CTRL -- requirements
Module: cmlk_frame_ctrl

---
 rtl/cmlk_frame_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_cmlk_frame_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmlk_frame_ctrl.sv
`default_nettype none
// cmlk_frame_ctrl: frame-gated AXI-Stream pass-through with line/frame geometry checks and status counters.
// Rev 1.0
module cmlk_frame_ctrl #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tuser,
  input  logic              s_axis_tlast,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  input  logic              cfg_enable,
  input  logic              cfg_single,
  input  logic              cfg_arm,
  input  logic [CNT_W-1:0]  cfg_line_beats,
  input  logic [CNT_W-1:0]  cfg_frame_lines,
  input  logic              sts_clr,
  output logic              sts_busy,
  output logic [31:0]       sts_frame_cnt,
  output logic [15:0]       sts_drop_cnt,
  output logic [15:0]       sts_line_err_cnt,
  output logic              sts_line_err,
  output logic              sts_frm_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_SOF = 2'd1, PASS = 2'd2} state_t;

  state_t            state_q, state_d, after_frame;
  logic [CNT_W-1:0]  beat_q, beat_d, line_q, line_d, lb_q, lb_d, fl_q, fl_d;
  logic              flag_q, flag_d;
  logic [31:0]       frame_cnt_q;
  logic [15:0]       drop_q, lerr_q;
  logic              line_err_q, frm_err_q;

  logic              s_rdy, m_vld, in_wait, accept, frame_done, drop_ev, line_err_ev;
  logic              flag_base;
  logic [CNT_W-1:0]  beat_base, line_base, lb_eff, fl_eff, beat_next, line_next;

  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tuser  = s_axis_tuser;
  assign m_axis_tlast  = s_axis_tlast;
  assign m_axis_tvalid = m_vld & rst_n;
  assign s_axis_tready = s_rdy;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    line_d      = line_q;
    lb_d        = lb_q;
    fl_d        = fl_q;
    flag_d      = flag_q;
    s_rdy       = 1'b1;
    m_vld       = 1'b0;
    accept      = 1'b0;
    frame_done  = 1'b0;
    drop_ev     = 1'b0;
    line_err_ev = 1'b0;
    after_frame = (cfg_single || !cfg_enable) ? IDLE : WAIT_SOF;
    // The SOF beat is checked against the live config, which becomes the shadow on acceptance.
    in_wait     = (state_q == WAIT_SOF);
    beat_base   = in_wait ? '0 : beat_q;
    line_base   = in_wait ? '0 : line_q;
    flag_base   = in_wait ? 1'b0 : flag_q;
    lb_eff      = in_wait ? cfg_line_beats : lb_q;
    fl_eff      = in_wait ? cfg_frame_lines : fl_q;
    beat_next   = beat_base + CNT_W'(1);
    line_next   = line_base + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (cfg_enable && (!cfg_single || cfg_arm)) state_d = WAIT_SOF;
      end
      WAIT_SOF: begin
        m_vld = s_axis_tvalid & s_axis_tuser;
        s_rdy = s_axis_tuser ? m_axis_tready : 1'b1;
        if (s_axis_tvalid && s_axis_tuser && m_axis_tready) begin
          accept  = 1'b1;
          lb_d    = cfg_line_beats;
          fl_d    = cfg_frame_lines;
          state_d = PASS;
        end else if (!cfg_enable) begin
          state_d = IDLE;
        end
      end
      PASS: begin
        if (s_axis_tvalid && s_axis_tuser) begin
          // A new SOF inside a frame is stalled and left for WAIT_SOF to forward.
          s_rdy = 1'b0;
          if (fl_q != '0) begin
            drop_ev = 1'b1;
            state_d = WAIT_SOF;
          end else begin
            frame_done = 1'b1;
            state_d    = after_frame;
          end
        end else begin
          m_vld  = s_axis_tvalid;
          s_rdy  = m_axis_tready;
          accept = s_axis_tvalid & m_axis_tready;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      if (s_axis_tlast) begin
        if (lb_eff != '0 && beat_next != lb_eff && !flag_base) line_err_ev = 1'b1;
        beat_d = '0;
        line_d = line_next;
        flag_d = 1'b0;
        if (fl_eff != '0 && line_next == fl_eff) begin
          frame_done = 1'b1;
          state_d    = after_frame;
        end
      end else begin
        // Overrun is reported once, when the expected last beat arrives without tlast.
        if (lb_eff != '0 && beat_next == lb_eff && !flag_base) begin
          line_err_ev = 1'b1;
          flag_d      = 1'b1;
        end else begin
          flag_d = flag_base;
        end
        beat_d = beat_next;
        line_d = line_base;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      line_q      <= '0;
      lb_q        <= '0;
      fl_q        <= '0;
      flag_q      <= 1'b0;
      frame_cnt_q <= '0;
      drop_q      <= '0;
      lerr_q      <= '0;
      line_err_q  <= 1'b0;
      frm_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      lb_q    <= lb_d;
      fl_q    <= fl_d;
      flag_q  <= flag_d;
      if (sts_clr) begin
        frame_cnt_q <= '0;
        drop_q      <= '0;
        lerr_q      <= '0;
        line_err_q  <= 1'b0;
        frm_err_q   <= 1'b0;
      end else begin
        if (frame_done) frame_cnt_q <= frame_cnt_q + 32'd1;
        if (drop_ev) begin
          frm_err_q <= 1'b1;
          if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
        end
        if (line_err_ev) begin
          line_err_q <= 1'b1;
          if (lerr_q != 16'hFFFF) lerr_q <= lerr_q + 16'd1;
        end
      end
    end
  end

  assign sts_busy         = (state_q != IDLE);
  assign sts_frame_cnt    = frame_cnt_q;
  assign sts_drop_cnt     = drop_q;
  assign sts_line_err_cnt = lerr_q;
  assign sts_line_err     = line_err_q;
  assign sts_frm_err      = frm_err_q;

endmodule
`default_nettype wire

// File: tb/tb_cmlk_frame_ctrl.sv
`default_nettype none
// tb_cmlk_frame_ctrl: directed table and sequence checks for cmlk_frame_ctrl.
// Rev 1.0
module tb_cmlk_frame_ctrl;
  localparam int DW = 64;
  localparam int CW = 16;

  logic clk;
  logic rst_n;
  logic [DW-1:0] s_axis_tdata;
  logic s_axis_tvalid, s_axis_tuser, s_axis_tlast;
  wire  logic s_axis_tready;
  wire  logic [DW-1:0] m_axis_tdata;
  wire  logic m_axis_tvalid, m_axis_tuser, m_axis_tlast;
  wire  logic m_axis_tready;
  logic cfg_enable, cfg_single, cfg_arm, sts_clr;
  logic [CW-1:0] cfg_line_beats, cfg_frame_lines;
  wire  logic sts_busy, sts_line_err, sts_frm_err;
  wire  logic [31:0] sts_frame_cnt;
  wire  logic [15:0] sts_drop_cnt, sts_line_err_cnt;

  logic mr_drv, bp_mode;
  logic tog = 1'b0;
  assign m_axis_tready = bp_mode ? tog : mr_drv;

  int n_chk = 0;
  int n_err = 0;
  int mirror_bad = 0;
  logic [63:0] got_d[$];
  logic        got_u[$];
  logic [63:0] exp_d[$];

  // Field order: en tv tu tl mr | exp_rdy exp_mv exp_busy
  typedef struct packed {
    logic en, tv, tu, tl, mr;
    logic rdy, mv, busy;
  } vec_t;
  vec_t vecs[16];

  cmlk_frame_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .cfg_enable(cfg_enable), .cfg_single(cfg_single), .cfg_arm(cfg_arm),
    .cfg_line_beats(cfg_line_beats), .cfg_frame_lines(cfg_frame_lines),
    .sts_clr(sts_clr), .sts_busy(sts_busy), .sts_frame_cnt(sts_frame_cnt),
    .sts_drop_cnt(sts_drop_cnt), .sts_line_err_cnt(sts_line_err_cnt),
    .sts_line_err(sts_line_err), .sts_frm_err(sts_frm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) tog <= ~tog;

  always @(posedge clk)
    if (rst_n && m_axis_tvalid && m_axis_tready) begin
      got_d.push_back(m_axis_tdata);
      got_u.push_back(m_axis_tuser);
    end

  always @(negedge clk)
    if (bp_mode && rst_n && sts_busy && s_axis_tvalid && (s_axis_tready !== m_axis_tready))
      mirror_bad++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cfg_enable = 1'b0; cfg_single = 1'b0; cfg_arm = 1'b0; sts_clr = 1'b0;
    mr_drv = 1'b1; bp_mode = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic u, input logic l);
    logic hs;
    int k;
    s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    hs = 1'b0;
    k  = 0;
    while (!hs && k < 50) begin
      @(negedge clk);
      hs = s_axis_tready;
      @(posedge clk);
      #1;
      k++;
    end
    if (!hs) chk("beat_timeout", 64'd0, 64'd1);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int lines, input int beats, input logic [63:0] base,
                            input logic clr_last, input logic fwd);
    logic [63:0] d;
    for (int l = 0; l < lines; l++)
      for (int b = 0; b < beats; b++) begin
        d = base + 64'(l * beats + b);
        sts_clr = clr_last && (l == lines - 1) && (b == beats - 1);
        send_beat(d, (l == 0 && b == 0), (b == beats - 1));
        sts_clr = 1'b0;
        if (fwd) exp_d.push_back(d);
      end
  endtask

  task automatic check_stream(input string name, input int mark);
    int bad;
    bad = 0;
    chk({name, "_count"}, 64'(got_d.size() - mark), 64'(exp_d.size()));
    for (int i = 0; i < exp_d.size(); i++)
      if (mark + i >= got_d.size() || got_d[mark + i] !== exp_d[i]) bad++;
    chk({name, "_data"}, 64'(bad), 64'd0);
    exp_d.delete();
  endtask

  initial begin
    int mark;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    cfg_line_beats = '0; cfg_frame_lines = '0;
    do_reset();

    // Reset: output gated and all status cleared
    rst_n = 1'b0; s_axis_tvalid = 1'b1; s_axis_tuser = 1'b1;
    @(negedge clk);
    chk("rst_mvalid", 64'(m_axis_tvalid), 64'd0);
    tick();
    rst_n = 1'b1; s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0;
    chk("rst_busy", 64'(sts_busy), 64'd0);
    chk("rst_frame_cnt", 64'(sts_frame_cnt), 64'd0);
    chk("rst_drop_cnt", 64'(sts_drop_cnt), 64'd0);
    chk("rst_lerr_cnt", 64'(sts_line_err_cnt), 64'd0);
    chk("rst_flags", 64'({sts_line_err, sts_frm_err}), 64'd0);

    // Cycle table: line_beats=2, frame_lines=2, continuous mode
    vecs[0]  = 8'b11001_100; vecs[1]  = 8'b11001_101; vecs[2]  = 8'b11100_011; vecs[3]  = 8'b11101_111;
    vecs[4]  = 8'b11011_111; vecs[5]  = 8'b10000_001; vecs[6]  = 8'b11001_111; vecs[7]  = 8'b11011_111;
    vecs[8]  = 8'b11001_101; vecs[9]  = 8'b11101_111; vecs[10] = 8'b11101_001; vecs[11] = 8'b11101_111;
    vecs[12] = 8'b01011_111; vecs[13] = 8'b01001_111; vecs[14] = 8'b01011_111; vecs[15] = 8'b01101_100;
    do_reset();
    cfg_line_beats = 16'd2; cfg_frame_lines = 16'd2;
    for (int i = 0; i < 16; i++) begin
      cfg_enable = vecs[i].en; s_axis_tvalid = vecs[i].tv; s_axis_tuser = vecs[i].tu;
      s_axis_tlast = vecs[i].tl; mr_drv = vecs[i].mr;
      s_axis_tdata = 64'hA500_0000 + 64'(i);
      @(negedge clk);
      chk($sformatf("vec%0d_tready", i), 64'(s_axis_tready), 64'(vecs[i].rdy));
      chk($sformatf("vec%0d_tvalid", i), 64'(m_axis_tvalid), 64'(vecs[i].mv));
      chk($sformatf("vec%0d_busy", i), 64'(sts_busy), 64'(vecs[i].busy));
      chk($sformatf("vec%0d_tdata", i), m_axis_tdata, 64'hA500_0000 + 64'(i));
      tick();
    end
    idle(0);
    mr_drv = 1'b1;
    chk("tbl_frame_cnt", 64'(sts_frame_cnt), 64'd2);
    chk("tbl_drop_cnt", 64'(sts_drop_cnt), 64'd1);
    chk("tbl_frm_err", 64'(sts_frm_err), 64'd1);
    chk("tbl_lerr_cnt", 64'(sts_line_err_cnt), 64'd0);

    // Continuous: two clean 3x4 frames
    do_reset();
    cfg_line_beats = 16'd4; cfg_frame_lines = 16'd3; cfg_enable = 1'b1;
    idle(1);
    mark = got_d.size();
    send_frame(3, 4, 64'h100, 1'b0, 1'b1);
    send_frame(3, 4, 64'h200, 1'b0, 1'b1);
    idle(2);
    check_stream("cont", mark);
    chk("cont_frame_cnt", 64'(sts_frame_cnt), 64'd2);
    chk("cont_lerr_cnt", 64'(sts_line_err_cnt), 64'd0);
    chk("cont_flags", 64'({sts_line_err, sts_frm_err}), 64'd0);

    // Single-shot: arm while disabled is ignored, one frame per arm
    do_reset();
    cfg_line_beats = 16'd4; cfg_frame_lines = 16'd3; cfg_single = 1'b1;
    cfg_arm = 1'b1; tick(); cfg_arm = 1'b0; tick();
    chk("arm_disabled_ignored", 64'(sts_busy), 64'd0);
    cfg_enable = 1'b1; idle(2);
    chk("single_waits_arm", 64'(sts_busy), 64'd0);
    cfg_arm = 1'b1; tick(); cfg_arm = 1'b0;
    mark = got_d.size();
    send_frame(3, 4, 64'h300, 1'b0, 1'b1);
    send_frame(3, 4, 64'h400, 1'b0, 1'b0);
    send_frame(3, 4, 64'h500, 1'b0, 1'b0);
    idle(2);
    check_stream("single", mark);
    chk("single_frame_cnt", 64'(sts_frame_cnt), 64'd1);
    chk("single_idle", 64'(sts_busy), 64'd0);

    // Pre-SOF garbage discarded with tready high
    do_reset();
    cfg_line_beats = 16'd4; cfg_frame_lines = 16'd1; cfg_enable = 1'b1;
    idle(1);
    mark = got_d.size();
    for (int i = 0; i < 5; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
      s_axis_tdata = 64'hBAD0 + 64'(i);
      @(negedge clk);
      chk($sformatf("garbage%0d_tready", i), 64'(s_axis_tready), 64'd1);
      chk($sformatf("garbage%0d_tvalid", i), 64'(m_axis_tvalid), 64'd0);
      tick();
    end
    send_frame(1, 4, 64'h600, 1'b0, 1'b1);
    idle(1);
    if (got_d.size() > mark) chk("garbage_first_tuser", 64'(got_u[mark]), 64'd1);
    else chk("garbage_first_present", 64'd0, 64'd1);
    check_stream("garbage", mark);
    chk("garbage_frame_cnt", 64'(sts_frame_cnt), 64'd1);

    // Short line, then long line flagged once, then reset mid-frame
    do_reset();
    cfg_line_beats = 16'd4; cfg_frame_lines = 16'd3; cfg_enable = 1'b1;
    idle(1);
    mark = got_d.size();
    send_beat(64'h700, 1'b1, 1'b0); exp_d.push_back(64'h700);
    send_beat(64'h701, 1'b0, 1'b0); exp_d.push_back(64'h701);
    send_beat(64'h702, 1'b0, 1'b1); exp_d.push_back(64'h702);
    chk("short_lerr_cnt", 64'(sts_line_err_cnt), 64'd1);
    chk("short_lerr_flag", 64'(sts_line_err), 64'd1);
    for (int i = 0; i < 6; i++) begin
      send_beat(64'h710 + 64'(i), 1'b0, (i == 5));
      exp_d.push_back(64'h710 + 64'(i));
    end
    check_stream("short_long", mark);
    chk("long_lerr_once", 64'(sts_line_err_cnt), 64'd2);
    s_axis_tvalid = 1'b1; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = 64'h7FF;
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_truncates", 64'(m_axis_tvalid), 64'd0);
    tick();
    rst_n = 1'b1; idle(0);
    chk("reset_busy", 64'(sts_busy), 64'd0);
    chk("reset_lerr_cnt", 64'(sts_line_err_cnt), 64'd0);

    // Backpressure toggling, then clear coinciding with frame completion
    do_reset();
    cfg_line_beats = 16'd4; cfg_frame_lines = 16'd3; cfg_enable = 1'b1;
    idle(1);
    bp_mode = 1'b1;
    mark = got_d.size();
    send_frame(3, 4, 64'h800, 1'b0, 1'b1);
    bp_mode = 1'b0;
    idle(1);
    check_stream("bp", mark);
    chk("bp_ready_mirror", 64'(mirror_bad), 64'd0);
    chk("bp_frame_cnt", 64'(sts_frame_cnt), 64'd1);
    mark = got_d.size();
    send_frame(3, 4, 64'h900, 1'b1, 1'b1);
    idle(1);
    check_stream("clr", mark);
    chk("clr_wins_frame_cnt", 64'(sts_frame_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
